// File: rtl/column_expander_if.sv
// rtl/column_expander_if.sv - pair input, expanded output and status signals of the column expander
interface column_expander_if #(
  parameter int COL_WIDTH   = 32,
  parameter int COUNT_WIDTH = 5
);
  logic                   push_in;
  logic [COL_WIDTH-1:0]   in_col_index;
  logic [COUNT_WIDTH-1:0] in_count;
  logic                   stall_in;
  logic                   push_out;
  logic [COL_WIDTH-1:0]   out_col_index;
  logic                   almost_full;
  logic                   overflow;
  logic                   idle;

  modport master (
    output push_in, in_col_index, in_count, stall_in,
    input  push_out, out_col_index, almost_full, overflow, idle
  );

  modport slave (
    input  push_in, in_col_index, in_count, stall_in,
    output push_out, out_col_index, almost_full, overflow, idle
  );
endinterface

// File: rtl/column_expander.sv
// rtl/column_expander.sv - run-length expander replaying each (column, count) pair count+1 times
module column_expander #(
  parameter int COL_WIDTH   = 32,
  parameter int COUNT_WIDTH = 5,
  parameter int FIFO_LOG2   = 4,
  parameter int AF_SLACK    = 4
) (
  input  logic               clk,
  input  logic               reset,
  column_expander_if.slave   bus
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] DEPTH_V  = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2:0] AF_LEVEL = (FIFO_LOG2+1)'(DEPTH - AF_SLACK);

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  logic [COL_WIDTH-1:0]   mem_col_q [DEPTH];
  logic [COUNT_WIDTH-1:0] mem_cnt_q [DEPTH];

  state_t                 state_q, state_d;
  logic [FIFO_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]     occ_q, occ_d;
  logic [COL_WIDTH-1:0]   cur_col_q, cur_col_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   push_out_q, push_out_d;
  logic [COL_WIDTH-1:0]   out_col_q, out_col_d;
  logic                   almost_full_q, almost_full_d;
  logic                   overflow_q, overflow_d;
  logic                   idle_q, idle_d;

  logic fifo_full, fifo_empty, wr_en, pop;

  assign fifo_full  = (occ_q == DEPTH_V);
  assign fifo_empty = (occ_q == '0);

  always_comb begin
    state_d       = state_q;
    cur_col_d     = cur_col_q;
    remaining_d   = remaining_q;
    out_col_d     = out_col_q;
    push_out_d    = 1'b0;
    pop           = 1'b0;
    // Fullness is judged before this cycle's pop, so a same-cycle pop never rescues a push.
    wr_en         = bus.push_in && !fifo_full;
    overflow_d    = overflow_q || (bus.push_in && fifo_full);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          cur_col_d   = mem_col_q[rd_ptr_q];
          remaining_d = mem_cnt_q[rd_ptr_q];
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (!bus.stall_in) begin
          push_out_d = 1'b1;
          out_col_d  = cur_col_q;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - COUNT_WIDTH'(1);
          end else if (!fifo_empty) begin
            pop         = 1'b1;
            cur_col_d   = mem_col_q[rd_ptr_q];
            remaining_d = mem_cnt_q[rd_ptr_q];
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d      = wr_ptr_q + FIFO_LOG2'(wr_en);
    rd_ptr_d      = rd_ptr_q + FIFO_LOG2'(pop);
    occ_d         = occ_q + (FIFO_LOG2+1)'(wr_en) - (FIFO_LOG2+1)'(pop);
    almost_full_d = (occ_d >= AF_LEVEL);
    idle_d        = (occ_d == '0) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_col_q[wr_ptr_q] <= bus.in_col_index;
      mem_cnt_q[wr_ptr_q] <= bus.in_count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      cur_col_q     <= '0;
      remaining_q   <= '0;
      push_out_q    <= 1'b0;
      out_col_q     <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      cur_col_q     <= cur_col_d;
      remaining_q   <= remaining_d;
      push_out_q    <= push_out_d;
      out_col_q     <= out_col_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      idle_q        <= idle_d;
    end
  end

  assign bus.push_out      = push_out_q;
  assign bus.out_col_index = out_col_q;
  assign bus.almost_full   = almost_full_q;
  assign bus.overflow      = overflow_q;
  assign bus.idle          = idle_q;
endmodule
